// File: rtl/demux_one_hot_handshake.sv
// Registered one-hot / multicast demultiplexer with valid/ready flow control.
// A single producer word is captured into a holding buffer and presented on
// every channel named by SEL. The word stays put until each selected consumer
// has taken it, and channels drain independently of each other. Illegal or
// null destination masks consume the word without delivering it and bump a
// saturating drop counter.
module demux_one_hot_handshake #(
  parameter int WORD_WIDTH      = 8,
  parameter int WORD_COUNT      = 4,
  parameter int ALLOW_MULTICAST = 1,
  parameter int COUNT_WIDTH     = 16,
  localparam int TOTAL_WIDTH    = WORD_COUNT * WORD_WIDTH
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [WORD_COUNT-1:0]  sel_i,
  input  logic [WORD_WIDTH-1:0]  words_in_i,
  output logic [WORD_COUNT-1:0]  out_valid_o,
  input  logic [WORD_COUNT-1:0]  out_ready_i,
  output logic [TOTAL_WIDTH-1:0] words_out_o,
  output logic [COUNT_WIDTH-1:0] drop_count_o,
  output logic                   sel_error_o
);

  logic [WORD_WIDTH-1:0]  buf_q, buf_d;
  logic [WORD_COUNT-1:0]  pend_q, pend_d;
  logic [COUNT_WIDTH-1:0] drop_q, drop_d;
  logic                   sel_err_q, sel_err_d;

  logic [WORD_COUNT-1:0]  still_pending;
  logic                   accept;
  logic                   sel_zero;
  logic                   sel_multi;
  logic                   sel_legal;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v);
    if (v == {COUNT_WIDTH{1'b1}}) begin
      return v;
    end
    return v + 1'b1;
  endfunction

  // A mask is multi-hot when more than one destination bit is set.
  function automatic logic is_multi_hot(input logic [WORD_COUNT-1:0] v);
    return $countones(v) > 1;
  endfunction

  // Channels that will still hold the word after this edge. The block may take
  // a new word only when none remain, so a final drain and a new accept can
  // share a cycle and the stream runs at one word per clock.
  always_comb begin
    still_pending = pend_q & ~out_ready_i;
    in_ready_o    = (still_pending == '0);
    accept        = in_valid_i & in_ready_o;
    sel_zero      = (sel_i == '0);
    sel_multi     = is_multi_hot(sel_i);
    sel_legal     = !sel_zero && ((ALLOW_MULTICAST != 0) || !sel_multi);
  end

  // Next-state: drain accepted channels, capture a new word on accept, and
  // account for dropped words (null routes are silent, multi-hot routes flag).
  always_comb begin
    pend_d    = still_pending;
    buf_d     = buf_q;
    drop_d    = drop_q;
    sel_err_d = 1'b0;
    if (accept) begin
      buf_d = words_in_i;
      if (sel_legal) begin
        pend_d = sel_i;
      end else begin
        pend_d    = '0;
        drop_d    = sat_inc(drop_q);
        sel_err_d = sel_multi;
      end
    end
  end

  // State registers; reset discards any word still in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pend_q    <= '0;
      buf_q     <= '0;
      drop_q    <= '0;
      sel_err_q <= 1'b0;
    end else begin
      pend_q    <= pend_d;
      buf_q     <= buf_d;
      drop_q    <= drop_d;
      sel_err_q <= sel_err_d;
    end
  end

  // Per-channel output: the held word on pending channels, zero elsewhere so
  // drained or unselected consumers never see stale data.
  always_comb begin
    words_out_o = '0;
    for (int i = 0; i < WORD_COUNT; i++) begin
      if (pend_q[i]) begin
        words_out_o[WORD_WIDTH*i +: WORD_WIDTH] = buf_q;
      end
    end
  end

  assign out_valid_o  = pend_q;
  assign drop_count_o = drop_q;
  assign sel_error_o  = sel_err_q;

endmodule

// File: tb/tb_demux_one_hot_handshake.sv
// Bench for demux_one_hot_handshake: two instances (multicast with a wide
// counter, unicast-only with a 2-bit counter) share one stimulus stream and
// are each compared every cycle against a per-instance behavioural model.
module tb_demux_one_hot_handshake;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [3:0] sel;
  logic [7:0] din;
  logic [3:0] out_ready;

  logic        ir_mc, se_mc, ir_uc, se_uc;
  logic [3:0]  ov_mc, ov_uc;
  logic [31:0] wo_mc, wo_uc;
  logic [15:0] dc_mc;
  logic [1:0]  dc_uc;

  int n_checks = 0;
  int n_errors = 0;
  bit checks_on = 0;

  // Model state, index 0 = multicast instance, 1 = unicast-only instance.
  bit [3:0] m_pend [2];
  bit [7:0] m_buf  [2];
  int       m_drop [2];
  bit       m_err  [2];
  int       m_max  [2] = '{65535, 3};
  bit       m_mc   [2] = '{1'b1, 1'b0};

  always #5 clk = ~clk;

  demux_one_hot_handshake #(
    .WORD_WIDTH(8), .WORD_COUNT(4), .ALLOW_MULTICAST(1), .COUNT_WIDTH(16)
  ) u_mc (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(ir_mc),
    .sel_i(sel), .words_in_i(din), .out_valid_o(ov_mc), .out_ready_i(out_ready),
    .words_out_o(wo_mc), .drop_count_o(dc_mc), .sel_error_o(se_mc)
  );

  demux_one_hot_handshake #(
    .WORD_WIDTH(8), .WORD_COUNT(4), .ALLOW_MULTICAST(0), .COUNT_WIDTH(2)
  ) u_uc (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(ir_uc),
    .sel_i(sel), .words_in_i(din), .out_valid_o(ov_uc), .out_ready_i(out_ready),
    .words_out_o(wo_uc), .drop_count_o(dc_uc), .sel_error_o(se_uc)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Ready whenever no selected channel is left waiting on a not-ready consumer.
  function automatic bit m_ready(input int k);
    for (int c = 0; c < 4; c++) begin
      if (m_pend[k][c] && !out_ready[c]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic check_inst(input int k, input string nm, input logic ir, input logic [3:0] ov,
                            input logic [31:0] wo, input logic [31:0] dc, input logic se);
    logic [31:0] ew;
    ew = '0;
    for (int c = 0; c < 4; c++) begin
      if (m_pend[k][c]) ew[c*8 +: 8] = m_buf[k];
    end
    chk({nm, "_in_ready"},  {31'b0, ir}, {31'b0, m_ready(k)});
    chk({nm, "_out_valid"}, {28'b0, ov}, {28'b0, m_pend[k]});
    chk({nm, "_words_out"}, wo, ew);
    chk({nm, "_drop_cnt"},  dc, m_drop[k]);
    chk({nm, "_sel_err"},   {31'b0, se}, {31'b0, m_err[k]});
  endtask

  // Apply one rising edge to the model using the inputs present at that edge.
  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_pend[k] = '0; m_buf[k] = '0; m_drop[k] = 0; m_err[k] = 0;
      end else begin
        bit acc;
        bit [3:0] np;
        int n;
        acc = in_valid && m_ready(k);
        np = m_pend[k] & ~out_ready;
        m_err[k] = 0;
        if (acc) begin
          m_buf[k] = din;
          n = $countones(sel);
          if (n == 0 || (n > 1 && !m_mc[k])) begin
            np = '0;
            if (m_drop[k] < m_max[k]) m_drop[k]++;
            m_err[k] = (n > 1);
          end else begin
            np = sel;
          end
        end
        m_pend[k] = np;
      end
    end
  endtask

  // One clock: compare on the falling edge, advance the model at the rising
  // edge, then return 1 time unit later so the caller can change inputs.
  task automatic cycle();
    @(negedge clk);
    if (checks_on) begin
      check_inst(0, "mc", ir_mc, ov_mc, wo_mc, {16'b0, dc_mc}, se_mc);
      check_inst(1, "uc", ir_uc, ov_uc, wo_uc, {30'b0, dc_uc}, se_uc);
    end
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive(input bit v, input logic [3:0] s, input logic [7:0] d, input logic [3:0] r);
    in_valid = v; sel = s; din = d; out_ready = r;
  endtask

  initial begin
    logic [1:0] exp_sat [5];
    exp_sat = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

    // Reset held two cycles with a producer already asserting valid.
    rst = 1'b1;
    drive(1'b1, 4'b0001, 8'hEE, 4'hF);
    cycle();
    checks_on = 1;
    cycle();
    rst = 1'b0;
    drive(1'b0, 4'b0000, 8'h00, 4'hF);
    #1;
    chk("rst_out_valid", {28'b0, ov_mc}, 32'h0);
    chk("rst_words_out", wo_mc, 32'h0);
    chk("rst_drop_cnt",  {16'b0, dc_mc}, 32'h0);
    chk("rst_in_ready",  {31'b0, ir_mc}, 32'h1);

    // Unicast stream at full rate, one-cycle latency.
    drive(1'b1, 4'b0001, 8'hA1, 4'hF); cycle();
    chk("uni_w1", wo_mc, 32'h0000_00A1);
    drive(1'b1, 4'b0100, 8'hA2, 4'hF); cycle();
    chk("uni_w2", wo_mc, 32'h00A2_0000);
    drive(1'b1, 4'b1000, 8'hA3, 4'hF); cycle();
    chk("uni_w3", wo_mc, 32'hA300_0000);
    drive(1'b0, 4'b0000, 8'h00, 4'hF); cycle();
    chk("uni_empty", {28'b0, ov_mc}, 32'h0);

    // Backpressure on channel 1 for five cycles, producer holding a next word.
    drive(1'b1, 4'b0010, 8'h5C, 4'b1101); cycle();
    drive(1'b1, 4'b0001, 8'h77, 4'b1101);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_in_ready", {31'b0, ir_mc}, 32'h0);
      chk("bp_valid",    {28'b0, ov_mc}, 32'h2);
      chk("bp_data",     wo_mc, 32'h0000_5C00);
      cycle();
    end
    drive(1'b0, 4'b0000, 8'h00, 4'hF); cycle();
    chk("bp_drained", {28'b0, ov_mc}, 32'h0);

    // Multicast 1011 draining ch0, (nothing), ch3, ch1.
    drive(1'b1, 4'b1011, 8'hC4, 4'hF); cycle();
    drive(1'b1, 4'b0001, 8'hD5, 4'b0001); #1;
    chk("mc_c1_ready", {31'b0, ir_mc}, 32'h0); cycle();
    chk("mc_c1_pend",  {28'b0, ov_mc}, 32'hA);
    drive(1'b1, 4'b0001, 8'hD5, 4'b0000); #1;
    chk("mc_c2_ready", {31'b0, ir_mc}, 32'h0); cycle();
    chk("mc_c2_pend",  {28'b0, ov_mc}, 32'hA);
    drive(1'b1, 4'b0001, 8'hD5, 4'b1000); #1;
    chk("mc_c3_ready", {31'b0, ir_mc}, 32'h0); cycle();
    chk("mc_c3_pend",  {28'b0, ov_mc}, 32'h2);
    chk("mc_c3_data",  wo_mc, 32'h0000_C400);
    drive(1'b1, 4'b0001, 8'hD5, 4'b0010); #1;
    chk("mc_c4_ready", {31'b0, ir_mc}, 32'h1); cycle();
    chk("mc_next_word", wo_mc, 32'h0000_00D5);

    // Illegal multi-hot on the unicast-only instance, then a null route.
    rst = 1'b1; drive(1'b0, 4'b0000, 8'h00, 4'hF); cycle(); rst = 1'b0;
    drive(1'b1, 4'b0110, 8'h3E, 4'hF); cycle();
    chk("err_pulse", {31'b0, se_uc}, 32'h1);
    chk("err_valid", {28'b0, ov_uc}, 32'h0);
    chk("err_drop1", {30'b0, dc_uc}, 32'h1);
    drive(1'b0, 4'b0000, 8'h00, 4'hF); cycle();
    chk("err_pulse_end", {31'b0, se_uc}, 32'h0);
    drive(1'b1, 4'b0000, 8'h3F, 4'hF); cycle();
    chk("null_drop2", {30'b0, dc_uc}, 32'h2);
    chk("null_no_err", {31'b0, se_uc}, 32'h0);

    // Drop counter saturation at 3, then reset while a word is pending.
    rst = 1'b1; drive(1'b0, 4'b0000, 8'h00, 4'hF); cycle(); rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 4'b0000, 8'(i), 4'hF); cycle();
      chk("sat_drop", {30'b0, dc_uc}, {30'b0, exp_sat[i]});
    end
    drive(1'b1, 4'b0100, 8'h99, 4'h0); cycle();
    chk("pre_rst_pend", {28'b0, ov_uc}, 32'h4);
    rst = 1'b1; drive(1'b0, 4'b0000, 8'h00, 4'h0); cycle(); rst = 1'b0;
    chk("post_rst_pend", {28'b0, ov_uc}, 32'h0);
    chk("post_rst_words", wo_uc, 32'h0);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      int r;
      rst = ($urandom_range(63) == 0);
      in_valid = ($urandom_range(3) != 0);
      r = $urandom_range(7);
      if (r == 0)      sel = 4'b0000;
      else if (r < 5)  sel = 4'(1 << $urandom_range(3));
      else             sel = 4'($urandom);
      din = 8'($urandom);
      out_ready = 4'($urandom) | 4'($urandom);
      cycle();
    end
    rst = 1'b0;
    drive(1'b0, 4'b0000, 8'h00, 4'hF);
    cycle();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
